mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, is the memory address width.
REQ-002 Parameter DATA_W, default 8, is the memory data width.
REQ-003 Parameter RD_LAT, default 1 (legal 1..7), is the number of clk cycles from read_en high to data_rd valid.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-006 rN_valid  in  1  requester N (N=0,1) presents a request.
REQ-007 rN_ready  out  1  arbiter accepts requester N's request this cycle.
REQ-008 rN_we  in  1  1=write, 0=read.
REQ-009 rN_addr  in  ADDR_W  request address.
REQ-010 rN_wdata  in  DATA_W  write data (ignored for reads).
REQ-011 rN_rsp_valid  out  1  one-cycle completion pulse to requester N.
REQ-012 rN_rsp_rdata  out  DATA_W  read data; valid while rN_rsp_valid=1 on a read.
REQ-013 address  out  ADDR_W  memory address.
REQ-014 write_en / read_en  out  1 each  memory strobes.
REQ-015 data_wr  out  DATA_W  memory write data.
REQ-016 data_rd  in  DATA_W  memory read data.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-019 IDLE: if any rN_valid=1, exactly one rN_ready is driven high combinationally, for the requester chosen by round-robin; a request is accepted on the edge where rN_valid&&rN_ready=1.
REQ-020 Round-robin: pointer prio (reset 0); both valid -> grant rprio; one valid -> grant that one; after acceptance, prio = index of the non-granted requester.
REQ-021 On acceptance, owner id, we, addr and wdata are registered; IDLE->ISSUE.
REQ-022 ISSUE (exactly 1 cycle): address=registered addr; write_en=we; read_en=!we; data_wr=wdata if write, else 0. Write: ISSUE->RESP. Read: ISSUE->WAIT.
REQ-023 WAIT lasts RD_LAT cycles (down-counter); data_rd is registered into the response data register on the last WAIT edge; then ->RESP.
REQ-024 RESP (exactly 1 cycle): owner's rsp_valid=1; rsp_rdata=captured data for reads, 0 for writes; other requester's rsp_valid=0; then ->IDLE.
REQ-025 Latency from acceptance edge: write rsp_valid in 2nd cycle after it; read rsp_valid in (2+RD_LAT)th cycle after it.
REQ-026 rN_ready=0 in ISSUE, WAIT, RESP; back-to-back throughput is one transaction per 3 (write) or 3+RD_LAT (read) cycles.
REQ-027 write_en and read_en never both 1; both 0 outside ISSUE; address and data_wr are 0 outside ISSUE.
REQ-028 All memory-side outputs, rsp_valid, rsp_rdata and busy are registered or decoded from registered state only; rN_ready depends on state, prio and rN_valid.
REQ-029 A requester dropping rN_valid before acceptance withdraws its request without side effects; rN_* inputs are ignored outside acceptance.
REQ-030 rsp_rdata holds its last value until the next RESP overwrites it.

Reset
REQ-031 rst=0 at any time, including mid-transaction, immediately forces: state=IDLE, prio=0, WAIT counter=0, all outputs 0, captured registers 0; an in-flight transaction is dropped with no rsp_valid.
REQ-032 After rst returns high, the first edge with any rN_valid=1 follows REQ-019 using prio=0.

Verification
REQ-033 Single write: r0 we=1 addr=0x3 wdata=0xA5 -> r0_ready in same cycle; next cycle write_en=1 address=0x3 data_wr=0xA5; next cycle r0_rsp_valid=1, rsp_rdata=0.
REQ-034 Read, RD_LAT=1: r1 read addr=0x3, memory returns 0xA5 -> read_en one cycle; r1_rsp_valid=1, r1_rsp_rdata=0xA5 in 3rd cycle after acceptance.
REQ-035 Contention: r0 and r1 hold valid continuously after reset -> grants alternate r0,r1,r0,r1; never two rN_ready high together.
REQ-036 RD_LAT=3: read -> exactly 3 WAIT cycles, rsp_valid in 5th cycle after acceptance, busy high for 5 cycles.
REQ-037 Reset in WAIT: assert rst=0 during WAIT -> all outputs 0 immediately, no rsp_valid; after release with both requesting, r0 is granted first.
REQ-038 Check continuously: write_en&&read_en never 1; each acceptance yields exactly one rsp_valid to the same requester.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory, one transaction in flight.
// Latency: write response 2 cycles after acceptance, read response 2+RD_LAT cycles after acceptance.
// Backpressure: rN_ready is only offered in IDLE; requests are held off for the whole transaction.
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rsp_valid,
    output logic [DATA_W-1:0] r0_rsp_rdata,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] r1_rsp_rdata,
    output logic [ADDR_W-1:0] address,
    output logic              write_en,
    output logic              read_en,
    output logic [DATA_W-1:0] data_wr,
    input  logic [DATA_W-1:0] data_rd,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic              prio;
    logic              own;
    logic              we_q;
    logic [2:0]        cnt;

    logic              gnt1;
    logic              acc;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    // r1 wins when it is the only requester or when it holds priority.
    assign gnt1      = r1_valid && (!r0_valid || prio);
    assign r1_ready  = rst && (state == IDLE) && gnt1;
    assign r0_ready  = rst && (state == IDLE) && r0_valid && !gnt1;
    assign acc       = r0_ready || r1_ready;
    assign we_sel    = gnt1 ? r1_we    : r0_we;
    assign addr_sel  = gnt1 ? r1_addr  : r0_addr;
    assign wdata_sel = gnt1 ? r1_wdata : r0_wdata;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            prio         <= 1'b0;
            own          <= 1'b0;
            we_q         <= 1'b0;
            cnt          <= '0;
            address      <= '0;
            write_en     <= 1'b0;
            read_en      <= 1'b0;
            data_wr      <= '0;
            r0_rsp_valid <= 1'b0;
            r1_rsp_valid <= 1'b0;
            r0_rsp_rdata <= '0;
            r1_rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        state    <= ISSUE;
                        own      <= gnt1;
                        we_q     <= we_sel;
                        prio     <= !gnt1;
                        address  <= addr_sel;
                        write_en <= we_sel;
                        read_en  <= !we_sel;
                        data_wr  <= we_sel ? wdata_sel : '0;
                    end
                end
                ISSUE: begin
                    address  <= '0;
                    write_en <= 1'b0;
                    read_en  <= 1'b0;
                    data_wr  <= '0;
                    if (we_q) begin
                        state <= RESP;
                        if (own) begin
                            r1_rsp_valid <= 1'b1;
                            r1_rsp_rdata <= '0;
                        end else begin
                            r0_rsp_valid <= 1'b1;
                            r0_rsp_rdata <= '0;
                        end
                    end else begin
                        state <= WAIT;
                        cnt   <= 3'(RD_LAT);
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    // Memory data is valid on the final WAIT cycle only.
                    if (cnt == 3'd1) begin
                        state <= RESP;
                        if (own) begin
                            r1_rsp_valid <= 1'b1;
                            r1_rsp_rdata <= data_rd;
                        end else begin
                            r0_rsp_valid <= 1'b1;
                            r0_rsp_rdata <= data_rd;
                        end
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    r0_rsp_valid <= 1'b0;
                    r1_rsp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              r0_valid = 1'b0, r0_we = 1'b0;
    logic [ADDR_W-1:0] r0_addr = '0;
    logic [DATA_W-1:0] r0_wdata = '0;
    logic              r1_valid = 1'b0, r1_we = 1'b0;
    logic [ADDR_W-1:0] r1_addr = '0;
    logic [DATA_W-1:0] r1_wdata = '0;
    logic              r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
    logic [DATA_W-1:0] r0_rsp_rdata, r1_rsp_rdata;
    logic [ADDR_W-1:0] address;
    logic              write_en, read_en, busy;
    logic [DATA_W-1:0] data_wr;
    logic [DATA_W-1:0] data_rd = '0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
        .address(address), .write_en(write_en), .read_en(read_en), .data_wr(data_wr),
        .data_rd(data_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory: data_rd carries the addressed word only in the RD_LAT-th cycle after read_en.
    logic [DATA_W-1:0] mem [16];
    logic [ADDR_W-1:0] raddr = '0;
    int                mcnt = 0;
    always @(negedge clk) begin
        if (write_en) mem[address] = data_wr;
        if (mcnt > 0) mcnt = mcnt - 1;
        if (read_en) begin
            raddr = address;
            mcnt  = RD_LAT + 1;
        end
        data_rd = (mcnt == 1) ? mem[raddr] : DATA_W'($urandom);
    end

    // Reference model: one pending transaction, response time by arithmetic on acceptance cycle.
    int                n_tests = 0, n_fail = 0;
    int                t = 0, t_acc = 0, t_resp = 0, last_gnt = -1, prev_gnt = -1;
    logic              pend = 1'b0, prio_m = 1'b0, p_own = 1'b0, p_we = 1'b0;
    logic [ADDR_W-1:0] p_addr = '0;
    logic [DATA_W-1:0] p_wdata = '0, p_data = '0;
    logic [DATA_W-1:0] mem_ref [16];
    logic [DATA_W-1:0] hold_rd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rs,
                       input logic v0, input logic w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        logic idle_m, issue, resp, g1, e0, e1;
        @(negedge clk);
        rst = rs;
        r0_valid = v0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
        #1;
        t++;
        if (!rs) begin
            pend = 1'b0; prio_m = 1'b0;
            hold_rd[0] = '0; hold_rd[1] = '0;
        end
        idle_m = !pend;
        issue  = pend && (t == t_acc + 1);
        resp   = pend && (t == t_resp);
        g1     = v1 && (!v0 || prio_m);
        e0     = rs && idle_m && v0 && !g1;
        e1     = rs && idle_m && g1;
        if (resp) hold_rd[p_own] = p_we ? '0 : p_data;
        chk("r0_ready", r0_ready, e0);
        chk("r1_ready", r1_ready, e1);
        chk("busy", busy, !idle_m);
        chk("write_en", write_en, issue && p_we);
        chk("read_en", read_en, issue && !p_we);
        chk("address", address, issue ? p_addr : '0);
        chk("data_wr", data_wr, (issue && p_we) ? p_wdata : '0);
        chk("r0_rsp_valid", r0_rsp_valid, resp && !p_own);
        chk("r1_rsp_valid", r1_rsp_valid, resp && p_own);
        chk("r0_rsp_rdata", r0_rsp_rdata, hold_rd[0]);
        chk("r1_rsp_rdata", r1_rsp_rdata, hold_rd[1]);
        chk("we_re_excl", write_en && read_en, 1'b0);
        chk("ready_excl", r0_ready && r1_ready, 1'b0);
        if (resp) pend = 1'b0;
        last_gnt = -1;
        if (e0 || e1) begin
            pend    = 1'b1;
            t_acc   = t;
            p_own   = e1;
            p_we    = e1 ? w1 : w0;
            p_addr  = e1 ? a1 : a0;
            p_wdata = e1 ? d1 : d0;
            t_resp  = t + (p_we ? 2 : 2 + RD_LAT);
            if (p_we) mem_ref[p_addr] = p_wdata;
            p_data   = mem_ref[p_addr];
            prio_m   = !p_own;
            last_gnt = e1 ? 1 : 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b1, 1'b0, 1'($urandom), 4'($urandom), 8'($urandom),
                      1'b0, 1'($urandom), 4'($urandom), 8'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = DATA_W'($urandom);
            mem_ref[i] = mem[i];
        end
        hold_rd[0] = '0; hold_rd[1] = '0;

        // Reset state, with both requesters asserting valid.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 4'h1, 8'h11, 1'b1, 1'b0, 4'h2, 8'h22);
        idle(2);

        // Single write from r0, then read-back from r1.
        cyc(1'b1, 1'b1, 1'b1, 4'h3, 8'hA5, 1'b0, 1'b0, 4'h0, 8'h00);
        chk("write_grant", last_gnt, 0);
        idle(4);
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h3, 8'h5A);
        chk("read_grant", last_gnt, 1);
        idle(7);

        // Contention: both requesters hold valid; grants must alternate.
        prev_gnt = -1;
        for (int i = 0; i < 60; i++) begin
            cyc(1'b1, 1'b1, 1'($urandom), 4'($urandom), 8'($urandom),
                      1'b1, 1'($urandom), 4'($urandom), 8'($urandom));
            if (last_gnt >= 0) begin
                if (prev_gnt >= 0) chk("alternate", last_gnt, (prev_gnt == 0) ? 1 : 0);
                prev_gnt = last_gnt;
            end
        end
        idle(7);

        // Random traffic, including withdrawn requests.
        for (int i = 0; i < 400; i++)
            cyc(1'b1, ($urandom_range(0, 2) == 0), 1'($urandom), 4'($urandom), 8'($urandom),
                      ($urandom_range(0, 2) == 0), 1'($urandom), 4'($urandom), 8'($urandom));
        idle(7);

        // Reset while a read sits in WAIT, then both request: r0 must win.
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h7, 8'h00);
        chk("wait_read_grant", last_gnt, 1);
        idle(2);
        chk("in_wait", pend && !p_we && (t > t_acc + 1) && (t < t_resp), 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 4'h4, 8'h44, 1'b1, 1'b1, 4'h5, 8'h55);
        cyc(1'b0, 1'b1, 1'b1, 4'h4, 8'h44, 1'b1, 1'b1, 4'h5, 8'h55);
        cyc(1'b1, 1'b1, 1'b1, 4'h4, 8'h44, 1'b1, 1'b1, 4'h5, 8'h55);
        chk("first_after_rst", last_gnt, 0);
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 1'b1, 1'($urandom), 4'($urandom), 8'($urandom),
                      1'b1, 1'($urandom), 4'($urandom), 8'($urandom));
        idle(7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
